chess_move_input: RTL and testbench

//  Converts raw push-buttons into an 8x8 board cursor and a two-click move request.

---
 rtl/chess_move_input_if.sv | 11 +
 rtl/chess_move_input.sv | 172 +++++++++++++++++
 tb/tb_chess_move_input.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/chess_move_input_if.sv
// Move-request handshake between chess_move_input (master) and the board-state block (slave).
interface chess_move_input_if;
  logic       move_req;
  logic [5:0] move_from;
  logic [5:0] move_to;
  logic       move_ack;
  logic       move_ok;

  modport master (output move_req, move_from, move_to, input  move_ack, move_ok);
  modport slave  (input  move_req, move_from, move_to, output move_ack, move_ok);
endinterface

// File: rtl/chess_move_input.sv
// Push-button front end: synchronise/debounce five buttons, drive an 8x8 cursor and a two-click move request.
// Define CURSOR_WRAP_EN to wrap the cursor at board edges; by default it saturates.
//   state | meaning
//   IDLE  | no square selected, waiting for first centre click
//   SEL   | source square held in sel_sq, waiting for destination click
//   REQ   | move_req raised, waiting for move_ack from the board block
module chess_move_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic                      board_clk,
  input  logic                      reset,
  input  logic                      btn_u_i,
  input  logic                      btn_d_i,
  input  logic                      btn_l_i,
  input  logic                      btn_r_i,
  input  logic                      btn_c_i,
  chess_move_input_if.master        mv_if,
  output logic [5:0]                cursor_sq_o,
  output logic                      sel_valid_o,
  output logic [5:0]                sel_sq_o,
  output logic                      player_o,
  output logic [1:0]                fsm_state_o
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] SEL  = 2'b01;
  localparam logic [1:0] REQ  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  // bit order {c,r,l,d,u}
  logic [4:0]       btn_raw;
  logic [4:0]       sync1_q, sync2_q;
  logic [4:0]       lvl_q, lvl_prev_q;
  logic [CNT_W-1:0] cnt_q [5];
  logic [4:0]       pulse;

  assign btn_raw = {btn_c_i, btn_r_i, btn_l_i, btn_d_i, btn_u_i};

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == lvl_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_TC) begin
          cnt_q[i] <= '0;
          lvl_q[i] <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign pulse = lvl_q & ~lvl_prev_q;

  logic       p_u, p_d, p_l, p_r, p_c;
  assign p_u = pulse[0] & ~pulse[1];
  assign p_d = pulse[1] & ~pulse[0];
  assign p_l = pulse[2] & ~pulse[3];
  assign p_r = pulse[3] & ~pulse[2];
  assign p_c = pulse[4];

  logic [1:0] state_q, state_d;
  logic [2:0] row_q, row_d, col_q, col_d;
  logic       sel_valid_q, sel_valid_d;
  logic [5:0] sel_sq_q, sel_sq_d;
  logic [5:0] from_q, from_d, to_q, to_d;
  logic       player_q, player_d;
  logic [5:0] cursor;

  assign cursor = {row_q, col_q};

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (state_q != REQ) begin
`ifdef CURSOR_WRAP_EN
      if (p_u) row_d = row_q - 3'd1;
      if (p_d) row_d = row_q + 3'd1;
      if (p_l) col_d = col_q - 3'd1;
      if (p_r) col_d = col_q + 3'd1;
`else
      if (p_u && row_q != 3'd0) row_d = row_q - 3'd1;
      if (p_d && row_q != 3'd7) row_d = row_q + 3'd1;
      if (p_l && col_q != 3'd0) col_d = col_q - 3'd1;
      if (p_r && col_q != 3'd7) col_d = col_q + 3'd1;
`endif
    end
  end

  // Centre-click decisions use the registered (pre-move) cursor.
  always_comb begin
    state_d     = state_q;
    sel_valid_d = sel_valid_q;
    sel_sq_d    = sel_sq_q;
    from_d      = from_q;
    to_d        = to_q;
    player_d    = player_q;
    case (state_q)
      IDLE: begin
        if (p_c) begin
          state_d     = SEL;
          sel_sq_d    = cursor;
          sel_valid_d = 1'b1;
        end
      end
      SEL: begin
        if (p_c) begin
          if (cursor == sel_sq_q) begin
            state_d     = IDLE;
            sel_valid_d = 1'b0;
          end else begin
            state_d = REQ;
            from_d  = sel_sq_q;
            to_d    = cursor;
          end
        end
      end
      REQ: begin
        if (mv_if.move_ack) begin
          state_d     = IDLE;
          sel_valid_d = 1'b0;
          if (mv_if.move_ok) player_d = ~player_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      sel_valid_q <= 1'b0;
      sel_sq_q    <= '0;
      from_q      <= '0;
      to_q        <= '0;
      player_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      sel_valid_q <= sel_valid_d;
      sel_sq_q    <= sel_sq_d;
      from_q      <= from_d;
      to_q        <= to_d;
      player_q    <= player_d;
    end
  end

  assign mv_if.move_req  = (state_q == REQ);
  assign mv_if.move_from = from_q;
  assign mv_if.move_to   = to_q;
  assign cursor_sq_o     = cursor;
  assign sel_valid_o     = sel_valid_q;
  assign sel_sq_o        = sel_sq_q;
  assign player_o        = player_q;
  assign fsm_state_o     = state_q;

endmodule

// File: tb/tb_chess_move_input.sv
// Directed bench for chess_move_input with a 4-cycle debounce.
module tb_chess_move_input;
  logic       board_clk = 1'b0;
  logic       reset;
  logic       btn_u, btn_d, btn_l, btn_r, btn_c;
  logic [5:0] cursor_sq, sel_sq;
  logic       sel_valid, player;
  logic [1:0] fsm_state;
  int         n_vec = 0;
  int         n_err = 0;

  chess_move_input_if mv_if ();

  chess_move_input #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .board_clk   (board_clk),
    .reset       (reset),
    .btn_u_i     (btn_u),
    .btn_d_i     (btn_d),
    .btn_l_i     (btn_l),
    .btn_r_i     (btn_r),
    .btn_c_i     (btn_c),
    .mv_if       (mv_if),
    .cursor_sq_o (cursor_sq),
    .sel_valid_o (sel_valid),
    .sel_sq_o    (sel_sq),
    .player_o    (player),
    .fsm_state_o (fsm_state)
  );

  always #5 board_clk = ~board_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mask order {c,r,l,d,u}
  task automatic press(input logic [4:0] m);
    {btn_c, btn_r, btn_l, btn_d, btn_u} = m;
    repeat (10) @(negedge board_clk);
    {btn_c, btn_r, btn_l, btn_d, btn_u} = 5'b0;
    repeat (10) @(negedge board_clk);
  endtask

  task automatic ack(input logic ok);
    mv_if.move_ack = 1'b1;
    mv_if.move_ok  = ok;
    @(negedge board_clk);
    mv_if.move_ack = 1'b0;
    mv_if.move_ok  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge board_clk);
    reset = 1'b0;
    @(negedge board_clk);
  endtask

  initial begin
    {btn_c, btn_r, btn_l, btn_d, btn_u} = 5'b0;
    mv_if.move_ack = 1'b0;
    mv_if.move_ok  = 1'b0;
    do_reset();
    chk("rst_cursor", cursor_sq, 0);
    chk("rst_sel_valid", sel_valid, 0);
    chk("rst_sel_sq", sel_sq, 0);
    chk("rst_move_req", mv_if.move_req, 0);
    chk("rst_from", mv_if.move_from, 0);
    chk("rst_to", mv_if.move_to, 0);
    chk("rst_player", player, 0);
    chk("rst_state", fsm_state, 0);

    // held right button: one step, 7 edges after press
    btn_r = 1'b1;
    repeat (6) @(negedge board_clk);
    chk("r_lat6", cursor_sq, 0);
    @(negedge board_clk);
    chk("r_lat7", cursor_sq, 1);
    repeat (13) @(negedge board_clk);
    chk("r_held", cursor_sq, 1);
    btn_r = 1'b0;
    repeat (10) @(negedge board_clk);

    // bouncing down button then stable
    for (int i = 0; i < 5; i++) begin
      btn_d = ~btn_d;
      repeat (2) @(negedge board_clk);
    end
    chk("d_bounce", cursor_sq, 1);
    repeat (12) @(negedge board_clk);
    chk("d_stable", cursor_sq, 9);
    btn_d = 1'b0;
    repeat (10) @(negedge board_clk);

    // right edge
    press(5'b00001);
    for (int i = 0; i < 6; i++) press(5'b01000);
    chk("to_sq7", cursor_sq, 7);
    press(5'b01000);
`ifdef CURSOR_WRAP_EN
    chk("edge_r", cursor_sq, 0);
`else
    chk("edge_r", cursor_sq, 7);
`endif

    // legal move 12 -> 28
    do_reset();
    press(5'b00010);
    for (int i = 0; i < 4; i++) press(5'b01000);
    chk("to_sq12", cursor_sq, 12);
    press(5'b10000);
    chk("sel_state", fsm_state, 1);
    chk("sel_valid", sel_valid, 1);
    chk("sel_sq", sel_sq, 12);
    press(5'b00010);
    press(5'b00010);
    chk("to_sq28", cursor_sq, 28);
    press(5'b10000);
    chk("req_state", fsm_state, 2);
    chk("req_move_req", mv_if.move_req, 1);
    chk("req_from", mv_if.move_from, 12);
    chk("req_to", mv_if.move_to, 28);
    ack(1'b1);
    chk("ack_state", fsm_state, 0);
    chk("ack_move_req", mv_if.move_req, 0);
    chk("ack_sel_valid", sel_valid, 0);
    chk("ack_player", player, 1);
    chk("ack_from_hold", mv_if.move_from, 12);
    chk("ack_to_hold", mv_if.move_to, 28);

    // u&d cancel, diagonal applies both
    press(5'b00011);
    chk("ud_same", cursor_sq, 28);
    press(5'b01010);
    chk("diag", cursor_sq, 37);

    // select then cancel on same square
    press(5'b10000);
    chk("sel37", sel_sq, 37);
    press(5'b10000);
    chk("cancel_state", fsm_state, 0);
    chk("cancel_sel_valid", sel_valid, 0);
    chk("cancel_move_req", mv_if.move_req, 0);
    chk("cancel_player", player, 1);

    // c with simultaneous move compares pre-move cursor: cancel, cursor moves
    press(5'b10000);
    press(5'b11000);
    chk("cmove_state", fsm_state, 0);
    chk("cmove_cursor", cursor_sq, 38);

    // REQ ignores buttons; illegal ack keeps player
    press(5'b10000);
    press(5'b00100);
    press(5'b10000);
    chk("req2_state", fsm_state, 2);
    press(5'b10100);
    chk("req_ign_cursor", cursor_sq, 37);
    chk("req_ign_state", fsm_state, 2);
    chk("req_ign_from", mv_if.move_from, 38);
    chk("req_ign_to", mv_if.move_to, 37);
    ack(1'b0);
    chk("nak_state", fsm_state, 0);
    chk("nak_player", player, 1);
    ack(1'b1);
    chk("idle_ack_player", player, 1);
    chk("idle_ack_state", fsm_state, 0);

    // async reset during REQ
    press(5'b10000);
    press(5'b01000);
    press(5'b10000);
    chk("req3_move_req", mv_if.move_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_move_req", mv_if.move_req, 0);
    chk("arst_cursor", cursor_sq, 0);
    chk("arst_state", fsm_state, 0);
    chk("arst_player", player, 0);
    chk("arst_sel_valid", sel_valid, 0);
    chk("arst_from", mv_if.move_from, 0);
    @(negedge board_clk);
    reset = 1'b0;
    repeat (2) @(negedge board_clk);
    chk("post_rst_move_req", mv_if.move_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
